// File: rtl/rgb_pkg.sv
// Shared definitions for the RGBW word/bit converters (transmit and receive side).
package rgb_pkg;

    localparam int unsigned WORD_BITS_DFLT    = 32;
    // Empty-FIFO clocks before a stream reset (about 50 us at 96 MHz).
    localparam int unsigned STREAM_RESET_CLKS = 4800;
    localparam int unsigned IDLE_CNT_W_DFLT   = 13;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        RST_SYM = 2'd2
    } state_t;

endpackage

// File: rtl/rgb_gap_timer.sv
// Gap timer: counts enabled clocks, clears on demand, saturates at LIMIT-1
// and flags the terminal count while enabled there.
module rgb_gap_timer #(
    parameter int unsigned LIMIT = 4800,
    parameter int unsigned CNT_W = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(LIMIT - 1);

    // Saturating up-counter; clear has priority over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != TERM)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = en && (cnt == TERM);

endmodule

// File: rtl/rgbw_wrd2sbit.sv
// RGBW word-to-serial-bit converter: pops words from a FWFT FIFO and offers
// them MSB first, one bit symbol per handshake, inserting a stream-reset
// symbol after a programmed idle time following traffic.
// Optional feature macro: WRD2SBIT_WORD_CNT_EN (adds word_cnt output).
module rgbw_wrd2sbit
    import rgb_pkg::*;
#(
    parameter int unsigned WORD_BITS         = WORD_BITS_DFLT,
    parameter int unsigned IDLE_TIMEOUT_CLKS = STREAM_RESET_CLKS,
    parameter int unsigned CNT_W             = IDLE_CNT_W_DFLT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fifo_empty,
    input  logic [WORD_BITS-1:0] fifo_word,
    output logic                 fifo_rd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sbit_value,
    output logic                 out_stream_reset,
    output logic                 underrun
`ifdef WRD2SBIT_WORD_CNT_EN
    ,
    output logic [15:0]          word_cnt
`endif
);

    localparam int unsigned      BIT_W    = $clog2(WORD_BITS);
    localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(WORD_BITS - 1);

    state_t                 state;
    logic [WORD_BITS-1:0]   shift_q;
    logic [BIT_W-1:0]       bit_cnt;
    logic                   sent_any;
    logic                   run;
    logic [CNT_W-1:0]       idle_cnt;
    logic                   idle_tc;
    logic                   xfer;
    logic                   last_xfer;

    assign xfer      = out_valid && out_ready;
    assign last_xfer = (state == SHIFT) && xfer && (bit_cnt == '0);

    // run holds off popping until the first clock after reset release, so a
    // non-empty FIFO is never read while rst_n is low or just rising.
    assign fifo_rd = run && !fifo_empty && ((state == IDLE) || last_xfer);

    // Symbol outputs decode straight from the state and shift registers.
    assign out_valid        = (state != IDLE);
    assign out_sbit_value   = (state == SHIFT) && shift_q[WORD_BITS-1];
    assign out_stream_reset = (state == RST_SYM);

    rgb_gap_timer #(
        .LIMIT (IDLE_TIMEOUT_CLKS),
        .CNT_W (CNT_W)
    ) u_gap_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != IDLE),
        .en    ((state == IDLE) && fifo_empty && sent_any),
        .cnt   (idle_cnt),
        .tc    (idle_tc)
    );

    // Main FSM: word load, bit shifting, stream-reset insertion, underrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shift_q  <= '0;
            bit_cnt  <= '0;
            sent_any <= 1'b0;
            run      <= 1'b0;
            underrun <= 1'b0;
        end else begin
            run <= 1'b1;
            case (state)
                IDLE: begin
                    if (fifo_rd) begin
                        shift_q <= fifo_word;
                        bit_cnt <= LAST_IDX;
                        state   <= SHIFT;
                        // A word after some empty clocks means a gap inside a frame.
                        if (idle_cnt != '0) underrun <= 1'b1;
                    end else if (idle_tc) begin
                        state <= RST_SYM;
                    end
                end
                SHIFT: begin
                    if (xfer) begin
                        if (bit_cnt != '0) begin
                            shift_q <= shift_q << 1;
                            bit_cnt <= bit_cnt - BIT_W'(1);
                        end else if (fifo_rd) begin
                            shift_q <= fifo_word;
                            bit_cnt <= LAST_IDX;
                        end else begin
                            shift_q  <= shift_q << 1;
                            state    <= IDLE;
                            sent_any <= 1'b1;
                        end
                    end
                end
                RST_SYM: begin
                    if (xfer) begin
                        sent_any <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WRD2SBIT_WORD_CNT_EN
    // Completed-word counter: saturates, cleared by each stream-reset transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if ((state == RST_SYM) && xfer) begin
            word_cnt <= '0;
        end else if (last_xfer && (word_cnt != 16'hFFFF)) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rgbw_wrd2sbit.sv
// Directed self-checking bench for rgbw_wrd2sbit (FWFT FIFO model + bit sink).
module tb_rgbw_wrd2sbit;

    localparam int unsigned IDLE_T = 4800;

    logic        clk;
    logic        rst_n;
    logic        fifo_empty;
    logic [31:0] fifo_word;
    logic        fifo_rd;
    logic        out_valid;
    logic        out_ready;
    logic        out_sbit_value;
    logic        out_stream_reset;
    logic        underrun;
`ifdef WRD2SBIT_WORD_CNT_EN
    logic [15:0] word_cnt;
`endif

    rgbw_wrd2sbit #(
        .WORD_BITS         (32),
        .IDLE_TIMEOUT_CLKS (IDLE_T),
        .CNT_W             (13)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fifo_empty       (fifo_empty),
        .fifo_word        (fifo_word),
        .fifo_rd          (fifo_rd),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_sbit_value   (out_sbit_value),
        .out_stream_reset (out_stream_reset),
        .underrun         (underrun)
`ifdef WRD2SBIT_WORD_CNT_EN
        ,
        .word_cnt         (word_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] fq[$];
    logic [63:0] rx;
    int cyc = 0;
    int n_bits, n_rd, n_rst, rd_empty, max_run, run_len, first_v;
    int bit32_cyc, last_bit_cyc, srst_cyc, stall_bad, n_stall;
    int rd_cyc[4];
    logic stalled, stall_val, stall_rst;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        n_bits = 0; rx = '0; n_rd = 0; n_rst = 0; max_run = 0; run_len = 0;
        first_v = -1; bit32_cyc = -1; last_bit_cyc = -1; srst_cyc = -1;
        stall_bad = 0; n_stall = 0; stalled = 1'b0;
        for (int i = 0; i < 4; i++) rd_cyc[i] = -1;
    endtask

    // One clock: present FIFO head, sample just after the falling edge,
    // record what the next rising edge will see, then wait for the next fall.
    task automatic tick();
        fifo_empty = (fq.size() == 0);
        fifo_word  = fifo_empty ? 32'h0 : fq[0];
        #1;
        cyc++;
        if (stalled) begin
            if (!out_valid || out_sbit_value !== stall_val || out_stream_reset !== stall_rst)
                stall_bad++;
        end
        stalled   = out_valid && !out_ready;
        stall_val = out_sbit_value;
        stall_rst = out_stream_reset;
        if (stalled) n_stall++;
        if (fifo_rd) begin
            if (fifo_empty) rd_empty++;
            else void'(fq.pop_front());
            if (n_rd < 4) rd_cyc[n_rd] = cyc;
            n_rd++;
        end
        if (out_valid && first_v < 0) first_v = cyc;
        if (out_valid && !out_stream_reset) run_len++;
        else run_len = 0;
        if (run_len > max_run) max_run = run_len;
        if (out_valid && out_ready) begin
            if (out_stream_reset) begin
                n_rst++;
                srst_cyc = cyc;
            end else begin
                rx = {rx[62:0], out_sbit_value};
                n_bits++;
                last_bit_cyc = cyc;
                if (n_bits == 32) bit32_cyc = cyc;
            end
        end
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_srst();
        for (int i = 0; i < int'(IDLE_T) + 60 && n_rst == 0; i++) tick();
        chk("srst_seen", 64'(n_rst), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b0; fifo_empty = 1'b1; fifo_word = '0;
        rd_empty = 0;
        clr_mon();
        @(negedge clk);

        // 1: reset holds everything low, no pop while in reset.
        fq.push_back(32'hA500_0FF0);
        ticks(3);
        chk("rst_outs", 64'({fifo_rd, out_valid, out_sbit_value, out_stream_reset, underrun}), 64'd0);
        chk("rst_no_rd", 64'(n_rd), 64'd0);
`ifdef WRD2SBIT_WORD_CNT_EN
        chk("rst_wcnt", 64'(word_cnt), 64'd0);
`endif

        // 2: single word, then exactly one stream reset after the idle time.
        out_ready = 1'b1; rst_n = 1'b1;
        clr_mon();
        ticks(45);
        chk("w1_rd", 64'(n_rd), 64'd1);
        chk("w1_bits", 64'(n_bits), 64'd32);
        chk("w1_data", rx, 64'h0000_0000_A500_0FF0);
        chk("w1_latency", 64'(first_v - rd_cyc[0]), 64'd1);
        chk("w1_no_srst", 64'(n_rst), 64'd0);
`ifdef WRD2SBIT_WORD_CNT_EN
        chk("w1_wcnt", 64'(word_cnt), 64'd1);
`endif
        wait_srst();
        chk("srst_delay", 64'(srst_cyc - last_bit_cyc), 64'(IDLE_T + 1));
        ticks(30);
        chk("srst_once", 64'(n_rst), 64'd1);
        chk("w1_underrun", 64'(underrun), 64'd0);
`ifdef WRD2SBIT_WORD_CNT_EN
        chk("srst_wcnt", 64'(word_cnt), 64'd0);
`endif

        // 3: back-to-back words, no bubble, second pop on the 32nd transfer.
        clr_mon();
        fq.push_back(32'hFFFF_FFFF);
        fq.push_back(32'h0000_0000);
        ticks(75);
        chk("b2b_bits", 64'(n_bits), 64'd64);
        chk("b2b_data", rx, 64'hFFFF_FFFF_0000_0000);
        chk("b2b_run", 64'(max_run), 64'd64);
        chk("b2b_rd", 64'(n_rd), 64'd2);
        chk("b2b_rd2_cyc", 64'(rd_cyc[1] - bit32_cyc), 64'd0);
        wait_srst();

        // 4: back-pressure 1-0-0-1, outputs hold while stalled.
        clr_mon();
        fq.push_back(32'hC3A5_5A3C);
        for (int i = 0; i < 100; i++) begin
            out_ready = ((i % 4) == 0) || ((i % 4) == 3);
            tick();
        end
        chk("bp_bits", 64'(n_bits), 64'd32);
        chk("bp_data", rx, 64'h0000_0000_C3A5_5A3C);
        chk("bp_stable", 64'(stall_bad), 64'd0);
        chk("bp_stalled", 64'(n_stall != 0), 64'd1);
        out_ready = 1'b1;
        wait_srst();

        // 5: 100+ empty clocks between words -> sticky underrun, no stream reset.
        clr_mon();
        fq.push_back(32'h0F0F_0F0F);
        ticks(40);
        chk("ur_before", 64'(underrun), 64'd0);
        ticks(100);
        chk("ur_no_srst", 64'(n_rst), 64'd0);
        fq.push_back(32'hF0F0_F0F0);
        ticks(40);
        chk("ur_set", 64'(underrun), 64'd1);
        chk("ur_bits", 64'(n_bits), 64'd64);
        chk("ur_data", rx, 64'h0F0F_0F0F_F0F0_F0F0);
        wait_srst();
        chk("ur_sticky", 64'(underrun), 64'd1);

        // 6: reset after 10 bits drops the partial word.
        clr_mon();
        fq.push_back(32'h1234_5678);
        for (int i = 0; i < 50 && n_bits != 10; i++) tick();
        chk("mid_bits", 64'(n_bits), 64'd10);
        chk("mid_prefix", rx, 64'h048);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", 64'({fifo_rd, out_valid, out_sbit_value, out_stream_reset, underrun}), 64'd0);
        fq.push_back(32'h8000_0001);
        ticks(3);
        chk("mid_rst_rd", 64'(fifo_rd), 64'd0);
`ifdef WRD2SBIT_WORD_CNT_EN
        chk("mid_wcnt", 64'(word_cnt), 64'd0);
`endif
        rst_n = 1'b1;
        clr_mon();
        ticks(45);
        chk("post_rd", 64'(n_rd), 64'd1);
        chk("post_bits", 64'(n_bits), 64'd32);
        chk("post_data", rx, 64'h0000_0000_8000_0001);
        chk("post_no_srst", 64'(n_rst), 64'd0);
        chk("post_underrun", 64'(underrun), 64'd0);
        wait_srst();

        chk("no_underflow", 64'(rd_empty), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
